// File: rtl/ahbl_wrap4_sram_slave_pkg.sv
// ---------------------------------------------------------------------------
// ahbl_wrap4_sram_slave_pkg
// Shared AHB-Lite encodings (HTRANS / HSIZE / HBURST), the data-phase state
// type of the SRAM responder, and a byte-merge helper used both for the
// memory write path and for the read-after-write bypass.
// ---------------------------------------------------------------------------
package ahbl_wrap4_sram_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;

    // ERR1/ERR2 are the two cycles of an AHB ERROR response.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } dph_state_e;

    // Replace the bytes of old_word selected by mask with those of new_word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                result[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/ahbl_wrap4_sram_slave_if.sv
// ---------------------------------------------------------------------------
// ahbl_wrap4_sram_slave_if
// AHB-Lite slave-side bus bundle. HREADY is the bus-wide ready produced by
// the fabric (input to both master and slave); HREADYOUT is this slave's
// contribution (ahbls_hready_resp).
//   slave  modport : consumes address/control/write data, drives
//                    hready_resp / hresp / hrdata
//   master modport : the mirror image
// ---------------------------------------------------------------------------
interface ahbl_wrap4_sram_slave_if #(
    parameter int W_HADDR = 32,
    parameter int W_HDATA = 32
);
    logic               ahbls_hready;
    logic               ahbls_hready_resp;
    logic               ahbls_hresp;
    logic [W_HADDR-1:0] ahbls_haddr;
    logic               ahbls_hwrite;
    logic [1:0]         ahbls_htrans;
    logic [2:0]         ahbls_hsize;
    logic [2:0]         ahbls_hburst;
    logic [3:0]         ahbls_hprot;
    logic               ahbls_hmastlock;
    logic [W_HDATA-1:0] ahbls_hwdata;
    logic [W_HDATA-1:0] ahbls_hrdata;

    modport slave (
        input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans,
               ahbls_hsize, ahbls_hburst, ahbls_hprot, ahbls_hmastlock,
               ahbls_hwdata,
        output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata
    );

    modport master (
        output ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
               ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hwdata,
        input  ahbls_hready, ahbls_hready_resp, ahbls_hresp, ahbls_hrdata
    );
endinterface

// File: rtl/ahbl_wrap4_sram_slave_lane.sv
// ---------------------------------------------------------------------------
// ahbl_byte_lane_mask
// Little-endian byte-lane decoder: hsize + addr[1:0] -> 4-bit lane mask.
// Unsupported sizes (wider than a word) select no lanes.
//   hsize   in  transfer size
//   addr_lo in  haddr[1:0]
//   mask    out byte lane enables, bit i = byte lane i
// ---------------------------------------------------------------------------
module ahbl_byte_lane_mask
    import ahbl_wrap4_sram_slave_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] mask
);

    // Size/offset to lane decode.
    always_comb begin
        mask = 4'b0000;
        case (hsize)
            HSIZE_BYTE: mask = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                if (addr_lo[1]) begin
                    mask = 4'b1100;
                end else begin
                    mask = 4'b0011;
                end
            end
            HSIZE_WORD: mask = 4'b1111;
            default:    mask = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahbl_wrap4_sram_slave.sv
// ---------------------------------------------------------------------------
// ahbl_wrap4_sram_slave
// AHB-Lite responder backed by a word-addressed on-chip memory. Serves
// SINGLE and WRAP4 (NONSEQ + 3 SEQ) traffic with programmable wait states,
// byte-lane writes, a read-after-write bypass and a two-cycle ERROR for
// addresses beyond DEPTH words.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ahbl_wrap4_sram_slave_if.slave
// Optional build macro SRAM_RANDOM_STALL_EN adds 0..3 pseudo-random extra
// wait states per transfer from a 16-bit LFSR.
// ---------------------------------------------------------------------------
module ahbl_wrap4_sram_slave
    import ahbl_wrap4_sram_slave_pkg::*;
#(
    parameter int W_HADDR   = 32,
    parameter int W_HDATA   = 32,
    parameter int DEPTH     = 1024,
    parameter int WAIT_NSEQ = 1,
    parameter int WAIT_SEQ  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ahbl_wrap4_sram_slave_if.slave bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int W_CNT = 5;   // 15 programmed + 3 random extra

    logic [31:0]      mem_r [DEPTH];
    dph_state_e       state_r;
    logic [AW-1:0]    dph_idx_r;
    logic             dph_write_r;
    logic [3:0]       dph_mask_r;
    logic [W_CNT-1:0] wait_cnt_r;
    logic             hready_resp_r;
    logic             hresp_r;
    logic [31:0]      hrdata_r;

    logic             accept_s;
    logic             range_err_s;
    logic             can_start_s;
    logic             wr_commit_s;
    logic [AW-1:0]    addr_idx_s;
    logic [3:0]       addr_mask_s;
    logic [W_CNT-1:0] extra_s;
    logic [W_CNT-1:0] waits_s;
    logic [31:0]      rd_word_s;
    logic             unused_s;

    assign unused_s = ^{bus.ahbls_hprot, bus.ahbls_hmastlock, bus.ahbls_hburst};

    assign accept_s    = bus.ahbls_hready & bus.ahbls_htrans[1];
    assign addr_idx_s  = bus.ahbls_haddr[AW+1:2];
    assign range_err_s = |bus.ahbls_haddr[W_HADDR-1:AW+2];
    assign wr_commit_s = (state_r == ST_DATA) & hready_resp_r & dph_write_r;

    ahbl_byte_lane_mask u_lane (
        .hsize   (bus.ahbls_hsize),
        .addr_lo (bus.ahbls_haddr[1:0]),
        .mask    (addr_mask_s)
    );

`ifdef SRAM_RANDOM_STALL_EN
    logic [15:0] lfsr_r;

    // Free-running Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
        end
    end

    assign extra_s = {3'b000, lfsr_r[1:0]};
`else
    assign extra_s = 5'd0;
`endif

    // Wait count for the transfer being accepted.
    always_comb begin
        waits_s = 5'd0;
        if (bus.ahbls_htrans[0]) begin
            waits_s = W_CNT'(WAIT_SEQ) + extra_s;
        end else begin
            waits_s = W_CNT'(WAIT_NSEQ) + extra_s;
        end
    end

    // A new address phase may be taken when no data phase is stalling.
    always_comb begin
        can_start_s = 1'b0;
        case (state_r)
            ST_IDLE: can_start_s = 1'b1;
            ST_ERR2: can_start_s = 1'b1;
            ST_DATA: can_start_s = hready_resp_r;
            default: can_start_s = 1'b0;
        endcase
    end

    // Read word at acceptance, merging a same-edge write to the same word.
    always_comb begin
        rd_word_s = mem_r[addr_idx_s];
        if (wr_commit_s && (dph_idx_r == addr_idx_s)) begin
            rd_word_s = merge_bytes(mem_r[addr_idx_s], bus.ahbls_hwdata, dph_mask_r);
        end else begin
            rd_word_s = mem_r[addr_idx_s];
        end
    end

    // Data-phase sequencer with registered HREADYOUT/HRESP/HRDATA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            dph_idx_r     <= '0;
            dph_write_r   <= 1'b0;
            dph_mask_r    <= 4'b0000;
            wait_cnt_r    <= 5'd0;
            hready_resp_r <= 1'b1;
            hresp_r       <= 1'b0;
            hrdata_r      <= 32'h0000_0000;
        end else if (can_start_s) begin
            if (accept_s && range_err_s) begin
                state_r       <= ST_ERR1;
                dph_write_r   <= 1'b0;
                wait_cnt_r    <= 5'd0;
                hready_resp_r <= 1'b0;
                hresp_r       <= 1'b1;
            end else if (accept_s) begin
                state_r       <= ST_DATA;
                dph_idx_r     <= addr_idx_s;
                dph_write_r   <= bus.ahbls_hwrite;
                dph_mask_r    <= addr_mask_s;
                wait_cnt_r    <= waits_s;
                hready_resp_r <= (waits_s == 5'd0);
                hresp_r       <= 1'b0;
                hrdata_r      <= rd_word_s;
            end else begin
                state_r       <= ST_IDLE;
                dph_write_r   <= 1'b0;
                hready_resp_r <= 1'b1;
                hresp_r       <= 1'b0;
            end
        end else begin
            case (state_r)
                ST_ERR1: begin
                    state_r       <= ST_ERR2;
                    hready_resp_r <= 1'b1;
                    hresp_r       <= 1'b1;
                end
                ST_DATA: begin
                    // Still in wait states; release on the last one.
                    wait_cnt_r    <= wait_cnt_r - 5'd1;
                    hready_resp_r <= (wait_cnt_r == 5'd1);
                end
                default: begin
                    state_r       <= ST_IDLE;
                    hready_resp_r <= 1'b1;
                    hresp_r       <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane memory write on the completing data-phase edge; not reset.
    always_ff @(posedge clk) begin
        if (wr_commit_s) begin
            for (int i = 0; i < 4; i++) begin
                if (dph_mask_r[i]) begin
                    mem_r[dph_idx_r][8*i +: 8] <= bus.ahbls_hwdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.ahbls_hready_resp = hready_resp_r;
    assign bus.ahbls_hresp       = hresp_r;
    assign bus.ahbls_hrdata      = hrdata_r;

endmodule

// File: tb/tb_ahbl_wrap4_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahbl_wrap4_sram_slave
// Table-driven bench: a list of AHB transfers with hand-computed expected
// read data, response and data-phase length, replayed through a simple
// pipelined master, plus a hand-written mid-burst reset sequence.
// DUT built with WAIT_NSEQ=1, WAIT_SEQ=0.
// ---------------------------------------------------------------------------
module tb_ahbl_wrap4_sram_slave;
    import ahbl_wrap4_sram_slave_pkg::*;

    localparam int DEPTH = 1024;
    localparam int WN    = 1;
    localparam int WS    = 0;
    localparam int NV    = 36;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        chk_en;
    } vec_t;

    vec_t        vecs [NV];
    logic [31:0] act_rdata [NV];
    logic        act_resp [NV];
    logic        act_first_ready [NV];
    logic        act_first_resp [NV];
    int          act_cycles [NV];

    int checks = 0;
    int errors = 0;
    int dc;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ahbl_wrap4_sram_slave_if #(.W_HADDR(32), .W_HDATA(32)) bus ();

    assign bus.ahbls_hready = bus.ahbls_hready_resp;

    ahbl_wrap4_sram_slave #(
        .W_HADDR(32), .W_HDATA(32), .DEPTH(DEPTH),
        .WAIT_NSEQ(WN), .WAIT_SEQ(WS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic [31:0] addr, input logic wr,
                        input logic [2:0] size, input logic [1:0] trans,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input logic chk_en);
        vecs[i].addr      = addr;
        vecs[i].wr        = wr;
        vecs[i].size      = size;
        vecs[i].trans     = trans;
        vecs[i].wdata     = wdata;
        vecs[i].exp_rdata = exp_rdata;
        vecs[i].exp_err   = exp_err;
        vecs[i].chk_en    = chk_en;
        act_cycles[i]     = 0;
    endtask

    task automatic drive_addr(input int ca);
        if (ca < 0) begin
            bus.ahbls_htrans = HTRANS_IDLE;
            bus.ahbls_haddr  = 32'h0;
            bus.ahbls_hwrite = 1'b0;
            bus.ahbls_hsize  = HSIZE_WORD;
            bus.ahbls_hburst = HBURST_SINGLE;
        end else begin
            bus.ahbls_htrans = vecs[ca].trans;
            bus.ahbls_haddr  = vecs[ca].addr;
            bus.ahbls_hwrite = vecs[ca].wr;
            bus.ahbls_hsize  = vecs[ca].size;
            bus.ahbls_hburst = HBURST_WRAP4;
        end
    endtask

    // Pipelined master: vectors first..last; stops right after vector
    // abort_at enters its data phase (abort_at < 0: run to completion).
    task automatic run_seg(input int first, input int last, input int abort_at, output int dcyc);
        int   ca;
        int   da;
        int   guard;
        logic rdy;
        ca    = first;
        da    = -1;
        dcyc  = 0;
        guard = 0;
        drive_addr(ca);
        while ((ca >= 0 || da >= 0) && guard < 200) begin
            @(negedge clk);
            rdy = bus.ahbls_hready_resp;
            if (da >= 0) begin
                dcyc++;
                act_cycles[da]++;
                if (act_cycles[da] == 1) begin
                    act_first_ready[da] = rdy;
                    act_first_resp[da]  = bus.ahbls_hresp;
                end
                if (rdy) begin
                    act_rdata[da] = bus.ahbls_hrdata;
                    act_resp[da]  = bus.ahbls_hresp;
                end
            end
            @(posedge clk);
            #1;
            guard++;
            if (rdy) begin
                da = ca;
                if (ca >= 0) ca = (ca < last) ? ca + 1 : -1;
                bus.ahbls_hwdata = (da >= 0) ? vecs[da].wdata : 32'h0;
                if (da >= 0 && da == abort_at) return;
                drive_addr(ca);
            end
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("FAIL timeout segment %0d actual=%0d cycles required<200", first, guard);
        end
    endtask

    initial begin
        // idx addr wr size trans wdata exp_rdata err chk
        setv( 0, 32'h10, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        setv( 1, 32'h10, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        setv( 2, 32'h38, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'h11111111, 32'h0, 1'b0, 1'b1);
        setv( 3, 32'h3C, 1'b1, HSIZE_WORD, HTRANS_SEQ,    32'h22222222, 32'h0, 1'b0, 1'b1);
        setv( 4, 32'h30, 1'b1, HSIZE_WORD, HTRANS_SEQ,    32'h33333333, 32'h0, 1'b0, 1'b1);
        setv( 5, 32'h34, 1'b1, HSIZE_WORD, HTRANS_SEQ,    32'h44444444, 32'h0, 1'b0, 1'b1);
        setv( 6, 32'h30, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 32'h33333333, 1'b0, 1'b1);
        setv( 7, 32'h34, 1'b0, HSIZE_WORD, HTRANS_SEQ,    32'h0, 32'h44444444, 1'b0, 1'b1);
        setv( 8, 32'h38, 1'b0, HSIZE_WORD, HTRANS_SEQ,    32'h0, 32'h11111111, 1'b0, 1'b1);
        setv( 9, 32'h3C, 1'b0, HSIZE_WORD, HTRANS_SEQ,    32'h0, 32'h22222222, 1'b0, 1'b1);
        setv(10, 32'h40, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        setv(11, 32'h44, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        setv(12, 32'h40, 1'b1, HSIZE_BYTE, HTRANS_NONSEQ, 32'h00000011, 32'h0, 1'b0, 1'b1);
        setv(13, 32'h41, 1'b1, HSIZE_BYTE, HTRANS_NONSEQ, 32'h00002200, 32'h0, 1'b0, 1'b1);
        setv(14, 32'h42, 1'b1, HSIZE_BYTE, HTRANS_NONSEQ, 32'h00330000, 32'h0, 1'b0, 1'b1);
        setv(15, 32'h43, 1'b1, HSIZE_BYTE, HTRANS_NONSEQ, 32'h44000000, 32'h0, 1'b0, 1'b1);
        setv(16, 32'h40, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 32'h44332211, 1'b0, 1'b1);
        setv(17, 32'h46, 1'b1, HSIZE_HALF, HTRANS_NONSEQ, 32'hBEEF0000, 32'h0, 1'b0, 1'b1);
        setv(18, 32'h44, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 32'hBEEF0000, 1'b0, 1'b1);
        setv(19, 32'h50, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'hCAFEF00D, 32'h0, 1'b0, 1'b1);
        setv(20, 32'h50, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        setv(21, 32'h00, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'h12345678, 32'h0, 1'b0, 1'b1);
        setv(22, DEPTH*4, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
        setv(23, 32'h00, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 32'h12345678, 1'b0, 1'b1);
        setv(24, 32'h60, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        setv(25, 32'h64, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        setv(26, 32'h68, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        setv(27, 32'h6C, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        setv(28, 32'h60, 1'b1, HSIZE_WORD, HTRANS_NONSEQ, 32'hA1A1A1A1, 32'h0, 1'b0, 1'b1);
        setv(29, 32'h64, 1'b1, HSIZE_WORD, HTRANS_SEQ,    32'hA2A2A2A2, 32'h0, 1'b0, 1'b1);
        setv(30, 32'h68, 1'b1, HSIZE_WORD, HTRANS_SEQ,    32'hA3A3A3A3, 32'h0, 1'b0, 1'b0);
        setv(31, 32'h6C, 1'b1, HSIZE_WORD, HTRANS_SEQ,    32'hA4A4A4A4, 32'h0, 1'b0, 1'b0);
        setv(32, 32'h60, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 32'hA1A1A1A1, 1'b0, 1'b1);
        setv(33, 32'h64, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 32'hA2A2A2A2, 1'b0, 1'b1);
        setv(34, 32'h68, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 32'h0, 1'b0, 1'b1);
        setv(35, 32'h6C, 1'b0, HSIZE_WORD, HTRANS_NONSEQ, 32'h0, 32'h0, 1'b0, 1'b1);

        bus.ahbls_hprot     = 4'b0011;
        bus.ahbls_hmastlock = 1'b0;
        bus.ahbls_hwdata    = 32'h0;
        drive_addr(-1);

        repeat (3) @(negedge clk);
        chk("reset_hready_resp", {31'h0, bus.ahbls_hready_resp}, 32'h1);
        chk("reset_hresp", {31'h0, bus.ahbls_hresp}, 32'h0);
        chk("reset_hrdata", bus.ahbls_hrdata, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_hready_resp", {31'h0, bus.ahbls_hready_resp}, 32'h1);
        @(posedge clk);
        #1;

        run_seg(0, 1, -1, dc);
        chk("wr_rd_dcycles", dc, 32'd4);
        run_seg(2, 5, -1, dc);
        chk("wrap4_wr_dcycles", dc, 32'd5);
        run_seg(6, 9, -1, dc);
        chk("wrap4_rd_dcycles", dc, 32'd5);
        run_seg(10, 20, -1, dc);
        run_seg(21, 23, -1, dc);
        run_seg(24, 27, -1, dc);

        // Mid-burst reset: beat 3 is in its data phase when reset hits.
        run_seg(28, 31, 30, dc);
        rst_n = 1'b0;
        drive_addr(-1);
        @(negedge clk);
        chk("midreset_hready_resp", {31'h0, bus.ahbls_hready_resp}, 32'h1);
        chk("midreset_hresp", {31'h0, bus.ahbls_hresp}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run_seg(32, 35, -1, dc);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].chk_en) begin
                int exp_cyc;
                exp_cyc = vecs[i].exp_err ? 2 :
                          (vecs[i].trans == HTRANS_SEQ) ? 1 + WS : 1 + WN;
                chk($sformatf("v%0d_cycles", i), act_cycles[i], exp_cyc);
                chk($sformatf("v%0d_first_ready", i), {31'h0, act_first_ready[i]},
                    (exp_cyc == 1) ? 32'h1 : 32'h0);
                chk($sformatf("v%0d_first_resp", i), {31'h0, act_first_resp[i]},
                    {31'h0, vecs[i].exp_err});
                chk($sformatf("v%0d_resp", i), {31'h0, act_resp[i]}, {31'h0, vecs[i].exp_err});
                if (!vecs[i].wr && !vecs[i].exp_err) begin
                    chk($sformatf("v%0d_rdata", i), act_rdata[i], vecs[i].exp_rdata);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
